// File: rtl/div_iter_if.sv
// Divider request/response bundle between the execute stage and the HILO divider.
// Ports: start/signed_div/flush/a/b from the pipeline (master side);
//        busy/ready/result back from the divider (slave side).
interface div_iter_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic               signed_div;
  logic               flush;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               ready;
  logic [2*WIDTH-1:0] result;

  // Pipeline side: issues the operation and observes stall/result.
  modport master (
    output start, signed_div, flush, a, b,
    input  busy, ready, result
  );

  // Divider side.
  modport slave (
    input  start, signed_div, flush, a, b,
    output busy, ready, result
  );
endinterface

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider (DIV/DIVU), producer of the HILO write data.
// Latency: start accepted in IDLE, WIDTH CALC cycles, one-cycle ready strobe after; /0 answers next cycle.
// Backpressure: busy stalls the pipeline while a divide runs; flush cancels, rst overrides all.
// Ports: clk, rst (sync, active-high); bus (slave): start, signed_div, flush, a, b -> busy, ready,
//        result = {remainder, quotient} (hi = remainder, lo = quotient).
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  div_iter_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]         state;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   rem;      // partial remainder
  logic [WIDTH-1:0]   quo;      // dividend shifting out, quotient bits shifting in
  logic [WIDTH-1:0]   dvsr;     // magnitude of the divisor
  logic               neg_q;    // negate quotient at the end
  logic               neg_r;    // negate remainder at the end
  logic [2*WIDTH-1:0] result_r;
  logic               ready_r;

  // Operand magnitudes; raw values for DIVU. |most-negative| is still
  // correct when read as an unsigned WIDTH-bit number.
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  always_comb begin
    abs_a = bus.a;
    abs_b = bus.b;
    if (bus.signed_div && bus.a[WIDTH-1]) abs_a = -bus.a;
    if (bus.signed_div && bus.b[WIDTH-1]) abs_b = -bus.b;
  end

  // One restoring step. The shifted remainder never exceeds the dividend
  // prefix consumed so far, so the top bit of the WIDTH+1 difference is a
  // reliable sign for the trial subtraction.
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   diff;
  logic             ge;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  always_comb begin
    rem_shift = {rem, quo[WIDTH-1]};
    diff      = rem_shift - {1'b0, dvsr};
    ge        = ~diff[WIDTH];
    rem_next  = ge ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    quo_next  = {quo[WIDTH-2:0], ge};
    q_fix     = neg_q ? -quo_next : quo_next;
    r_fix     = neg_r ? -rem_next : rem_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      rem      <= '0;
      quo      <= '0;
      dvsr     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_r <= '0;
      ready_r  <= 1'b0;
    end else begin
      ready_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !bus.flush) begin
            neg_q <= bus.signed_div & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_r <= bus.signed_div & bus.a[WIDTH-1];
            rem   <= '0;
            quo   <= abs_a;
            dvsr  <= abs_b;
            count <= '0;
            if (bus.b != '0) begin
              state <= CALC;
            end else begin
              // Divide by zero: raw dividend in hi, all-ones quotient in lo.
              state    <= DONE;
              result_r <= {bus.a, {WIDTH{1'b1}}};
              ready_r  <= 1'b1;
            end
          end
        end
        CALC: begin
          if (bus.flush) begin
            state <= IDLE;
          end else begin
            rem   <= rem_next;
            quo   <= quo_next;
            count <= count + CW'(1);
            if (count == LAST) begin
              result_r <= {r_fix, q_fix};
              ready_r  <= 1'b1;
              state    <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // ready is only ever set on entry to DONE; a flush in that cycle kills it.
  assign bus.ready  = ready_r & ~bus.flush;
  assign bus.result = result_r;
  assign bus.busy   = ~rst & ((state == CALC) |
                              ((state == IDLE) & bus.start & ~bus.flush));

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: signed/unsigned divides, divide-by-zero,
// overflow, flush in IDLE/CALC/DONE, and reset in the middle of an operation.
module tb_div_iter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  div_iter_if #(.WIDTH(32)) bus();

  div_iter #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // one more unit later, well away from the next edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Issue one divide in the current cycle (cycle 0). start is held through
  // the stall and dropped in the ready cycle, as the pipeline would.
  task automatic run_div(input string tag, input logic sd, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int lat);
    bus.start      = 1'b1;
    bus.signed_div = sd;
    bus.a          = a;
    bus.b          = b;
    for (int c = 0; c <= lat; c++) begin
      if (c == lat) bus.start = 1'b0;
      #1;
      chk({tag, " busy"}, bus.busy, c < lat);
      chk({tag, " ready"}, bus.ready, c == lat);
      if (c == lat) chk({tag, " result"}, bus.result, exp);
      next_cycle();
    end
    #1;
    chk({tag, " ready after"}, bus.ready, 1'b0);
    chk({tag, " busy after"}, bus.busy, 1'b0);
    next_cycle();
  endtask

  initial begin
    rst            = 1'b1;
    bus.start      = 1'b1;
    bus.signed_div = 1'b0;
    bus.flush      = 1'b0;
    bus.a          = 32'd100;
    bus.b          = 32'd7;
    next_cycle();
    next_cycle();
    #1;
    chk("reset busy", bus.busy, 1'b0);
    chk("reset ready", bus.ready, 1'b0);
    chk("reset result", bus.result, 64'h0);
    rst       = 1'b0;
    bus.start = 1'b0;
    #1;
    chk("idle busy", bus.busy, 1'b0);
    next_cycle();

    run_div("divu 100/7",      1'b0, 32'd100,      32'd7,        64'h00000002_0000000E, 33);
    run_div("div -7/2",        1'b1, 32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, 33);
    run_div("div 7/-2",        1'b1, 32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33);
    run_div("div ovf",         1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33);
    run_div("divu max/1",      1'b0, 32'hFFFFFFFF, 32'd1,        64'h00000000_FFFFFFFF, 33);
    run_div("divu max/c0",     1'b0, 32'hFFFFFFFF, 32'hC0000000, 64'h3FFFFFFF_00000001, 33);
    run_div("div -100/7",      1'b1, 32'hFFFFFF9C, 32'd7,        64'hFFFFFFFE_FFFFFFF2, 33);
    run_div("divu /0",         1'b0, 32'h12345678, 32'd0,        64'h12345678_FFFFFFFF, 1);
    run_div("div neg/0",       1'b1, 32'hFFFFFFF9, 32'd0,        64'hFFFFFFF9_FFFFFFFF, 1);

    // start together with flush in IDLE is not accepted.
    bus.start      = 1'b1;
    bus.flush      = 1'b1;
    bus.signed_div = 1'b0;
    bus.a          = 32'd100;
    bus.b          = 32'd7;
    #1;
    chk("idle flush busy", bus.busy, 1'b0);
    next_cycle();
    bus.start = 1'b0;
    bus.flush = 1'b0;
    #1;
    chk("idle flush busy next", bus.busy, 1'b0);
    chk("idle flush ready", bus.ready, 1'b0);
    chk("idle flush result", bus.result, 64'hFFFFFFF9_FFFFFFFF);
    next_cycle();

    // Flush in cycle 10 of a 100/7 divide, then 9/3 from cycle 11.
    bus.start = 1'b1;
    bus.a     = 32'd100;
    bus.b     = 32'd7;
    for (int c = 0; c < 10; c++) next_cycle();
    bus.flush = 1'b1;
    bus.start = 1'b0;
    #1;
    chk("calc flush busy", bus.busy, 1'b1);
    chk("calc flush ready", bus.ready, 1'b0);
    next_cycle();
    bus.flush = 1'b0;
    #1;
    chk("post flush busy", bus.busy, 1'b0);
    chk("post flush ready", bus.ready, 1'b0);
    chk("post flush result", bus.result, 64'hFFFFFFF9_FFFFFFFF);
    run_div("divu 9/3 after flush", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33);

    // Flush landing on the ready cycle suppresses the strobe.
    bus.start      = 1'b1;
    bus.signed_div = 1'b1;
    bus.a          = 32'hCAFEF00D;
    bus.b          = 32'd0;
    next_cycle();
    bus.start = 1'b0;
    bus.flush = 1'b1;
    #1;
    chk("done flush ready", bus.ready, 1'b0);
    chk("done flush result", bus.result, 64'hCAFEF00D_FFFFFFFF);
    next_cycle();
    bus.flush = 1'b0;
    #1;
    chk("done flush ready next", bus.ready, 1'b0);
    chk("done flush busy next", bus.busy, 1'b0);
    next_cycle();

    // Reset asserted in cycle 20 of an active divide.
    bus.start      = 1'b1;
    bus.signed_div = 1'b0;
    bus.a          = 32'd100;
    bus.b          = 32'd7;
    for (int c = 0; c < 20; c++) next_cycle();
    rst       = 1'b1;
    bus.start = 1'b0;
    #1;
    chk("rst busy", bus.busy, 1'b0);
    next_cycle();
    #1;
    chk("post rst busy", bus.busy, 1'b0);
    chk("post rst ready", bus.ready, 1'b0);
    chk("post rst result", bus.result, 64'h0);
    rst = 1'b0;
    next_cycle();
    run_div("divu 9/3 after rst", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
